// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared configuration for the operation receive path.
// Holds the word and opcode types, the header sync nibble, the frame
// geometry and the read-controller state encoding.
package operand_fetch_ctrl_pkg;

  localparam int DATA_W = 20;
  localparam int CODE_W = 4;
  localparam logic [3:0] SYNC = 4'hA;

  // Payload words following the header: A, B, C_lo, C_hi.
  localparam logic [2:0] PAY_WORDS = 3'd4;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [2*DATA_W-1:0] w_data_t;
  typedef logic [CODE_W-1:0]   code_t;

  typedef enum logic [1:0] {
    HDR_REQ = 2'd0,
    HDR_CHK = 2'd1,
    PAYLOAD = 2'd2,
    ISSUE   = 2'd3
  } state_t;

  // Header is accepted only when its top nibble carries the sync pattern.
  function automatic logic hdr_ok(input data_t w);
    return w[DATA_W-1 -: 4] == SYNC;
  endfunction

endpackage

// File: rtl/operand_fetch_ctrl.sv
// Read-side controller for the operation receive path.
// Pops five-word frames (header, A, B, C_lo, C_hi) from the receive FIFO,
// validates the header sync nibble, assembles the operation and offers it
// to the execution stage over valid/ready.
//
// Ports:
//   clk, arst_ni      clock, asynchronous active-low reset
//   fifo_empty_i      receive FIFO empty
//   rd_en_o           FIFO pop; data appears on rd_data_i one cycle later
//   rd_data_i         FIFO read data
//   flush_i           synchronous abort of partial frame / pending operation
//   op_code_o         opcode from header bits [CODE_W-1:0]
//   operand_a_o/b_o   payload words 1 and 2
//   operand_c_o       {payload word 4, payload word 3}
//   op_valid_o        operation available
//   op_ready_i        execution stage accepts
//   frame_err_o       one-cycle pulse for a rejected header
//   busy_o            controller is mid-frame or holding an operation
module operand_fetch_ctrl
  import operand_fetch_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    arst_ni,
  input  logic    fifo_empty_i,
  output logic    rd_en_o,
  input  data_t   rd_data_i,
  input  logic    flush_i,
  output code_t   op_code_o,
  output data_t   operand_a_o,
  output data_t   operand_b_o,
  output w_data_t operand_c_o,
  output logic    op_valid_o,
  input  logic    op_ready_i,
  output logic    frame_err_o,
  output logic    busy_o
);

  state_t     state, state_nxt;
  logic       rd_en;
  logic       run;       // low for the first cycle out of reset so no pop is
                         // issued while reset is (or was just) asserted
  logic       pend;      // a payload pop was issued last cycle; data is on rd_data_i
  logic [2:0] iss_cnt;   // payload pops issued for this frame
  logic [2:0] cap_cnt;   // payload words captured for this frame
  code_t      op_code;
  data_t      opa, opb, opc_lo, opc_hi;
  logic       frame_err;

  // ---------------------------------------------------------------------
  // Next state and FIFO pop
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      HDR_REQ: begin
        // Only one header read in flight: pop, then check before popping again.
        if (run && !fifo_empty_i) begin
          rd_en     = 1'b1;
          state_nxt = HDR_CHK;
        end
      end
      HDR_CHK: begin
        state_nxt = hdr_ok(rd_data_i) ? PAYLOAD : HDR_REQ;
      end
      PAYLOAD: begin
        // Payload pops stream back to back; captures trail by one cycle.
        rd_en = !fifo_empty_i && (iss_cnt < PAY_WORDS);
        if (pend && cap_cnt == PAY_WORDS - 3'd1)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        if (op_ready_i)
          state_nxt = HDR_REQ;
      end
      default: state_nxt = HDR_REQ;
    endcase
    // Flush wins over everything. Any word returning in the flush cycle is
    // dropped below, and no pop is issued, so nothing stale survives it.
    if (flush_i) begin
      state_nxt = HDR_REQ;
      rd_en     = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // State, handshake bookkeeping and error pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      state     <= HDR_REQ;
      run       <= 1'b0;
      pend      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      run       <= 1'b1;
      pend      <= rd_en && (state == PAYLOAD);
      frame_err <= (state == HDR_CHK) && !hdr_ok(rd_data_i) && !flush_i;
    end
  end

  // ---------------------------------------------------------------------
  // Counters and operand registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      iss_cnt <= '0;
      cap_cnt <= '0;
      op_code <= '0;
      opa     <= '0;
      opb     <= '0;
      opc_lo  <= '0;
      opc_hi  <= '0;
    end else if (!flush_i) begin
      if (state == HDR_CHK && hdr_ok(rd_data_i)) begin
        op_code <= rd_data_i[CODE_W-1:0];
        iss_cnt <= '0;
        cap_cnt <= '0;
      end
      if (state == PAYLOAD) begin
        if (rd_en)
          iss_cnt <= iss_cnt + 3'd1;
        if (pend) begin
          cap_cnt <= cap_cnt + 3'd1;
          case (cap_cnt[1:0])
            2'd0:    opa    <= rd_data_i;
            2'd1:    opb    <= rd_data_i;
            2'd2:    opc_lo <= rd_data_i;
            default: opc_hi <= rd_data_i;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all taken from registers, so they hold while op_valid_o waits
  // ---------------------------------------------------------------------
  assign rd_en_o     = rd_en;
  assign op_valid_o  = (state == ISSUE);
  assign op_code_o   = op_code;
  assign operand_a_o = opa;
  assign operand_b_o = opb;
  assign operand_c_o = {opc_hi, opc_lo};
  assign frame_err_o = frame_err;
  // A flush never leaves a read in flight, so HDR_REQ always means idle.
  assign busy_o      = (state != HDR_REQ);

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed bench for operand_fetch_ctrl: a behavioural FIFO feeds frames,
// outputs are sampled 1 time unit after the falling edge.
module tb_operand_fetch_ctrl;

  logic        clk = 1'b0;
  logic        arst_ni;
  logic        fifo_empty = 1'b1;
  logic        rd_en;
  logic [19:0] rd_data = '0;
  logic        flush;
  logic [3:0]  op_code;
  logic [19:0] operand_a, operand_b;
  logic [39:0] operand_c;
  logic        op_valid;
  logic        op_ready;
  logic        frame_err;
  logic        busy;

  logic        starve;
  logic [19:0] q[$];
  int          err_cnt = 0;
  int          tests = 0;
  int          fails = 0;
  int          n;

  operand_fetch_ctrl dut (
    .clk          (clk),
    .arst_ni      (arst_ni),
    .fifo_empty_i (fifo_empty),
    .rd_en_o      (rd_en),
    .rd_data_i    (rd_data),
    .flush_i      (flush),
    .op_code_o    (op_code),
    .operand_a_o  (operand_a),
    .operand_b_o  (operand_b),
    .operand_c_o  (operand_c),
    .op_valid_o   (op_valid),
    .op_ready_i   (op_ready),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle read latency, empty flag refreshed on falling edge.
  always @(posedge clk) if (rd_en && q.size() > 0) rd_data <= q.pop_front();
  always @(negedge clk) fifo_empty <= starve || (q.size() == 0);
  always @(posedge clk) if (frame_err === 1'b1) err_cnt <= err_cnt + 1;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push5(input logic [19:0] h, input logic [19:0] a, input logic [19:0] b,
                       input logic [19:0] cl, input logic [19:0] ch);
    q.push_back(h); q.push_back(a); q.push_back(b); q.push_back(cl); q.push_back(ch);
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (op_valid !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    chk("valid_seen", op_valid, 1);
  endtask

  initial begin
    arst_ni = 1'b0; flush = 1'b0; op_ready = 1'b1; starve = 1'b0;

    // ---- reset state, FIFO already holding a frame ----
    push5(20'hA0003, 20'hDEADF, 20'hCAFEA, 20'hFADED, 20'hCBBDE);
    repeat (3) step();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_valid", op_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_code", op_code, 0);
    chk("rst_a", operand_a, 0);
    chk("rst_b", operand_b, 0);
    chk("rst_c", operand_c, 0);
    arst_ni = 1'b1;

    // ---- nominal frame, best-case timing ----
    step(); chk("nom_c0_rd", rd_en, 1); chk("nom_c0_busy", busy, 0);
    step(); chk("nom_c1_rd", rd_en, 0); chk("nom_c1_busy", busy, 1);
    step(); chk("nom_c2_rd", rd_en, 1);
    step(); step(); step(); chk("nom_c5_rd", rd_en, 1);
    step(); chk("nom_c6_rd", rd_en, 0); chk("nom_c6_valid", op_valid, 0);
    step(); chk("nom_c7_valid", op_valid, 1);
    chk("nom_code", op_code, 4'h3);
    chk("nom_a", operand_a, 20'hDEADF);
    chk("nom_b", operand_b, 20'hCAFEA);
    chk("nom_c", operand_c, 40'hCBBDEFADED);
    step(); chk("nom_c8_valid", op_valid, 0); chk("nom_c8_busy", busy, 0);

    // ---- bad header then a good frame ----
    q.push_back(20'h50001);
    push5(20'hA1235, 20'h11111, 20'h22222, 20'h33333, 20'h44444);
    step(); chk("bad_t0_rd", rd_en, 1);
    step(); chk("bad_t1_err", frame_err, 0);
    step(); chk("bad_t2_err", frame_err, 1); chk("bad_t2_rd", rd_en, 1); chk("bad_t2_busy", busy, 0);
    step(); chk("bad_t3_err", frame_err, 0);
    wait_valid(n);
    chk("bad_latency", n, 6);
    chk("bad_code", op_code, 4'h5);
    chk("bad_a", operand_a, 20'h11111);
    chk("bad_b", operand_b, 20'h22222);
    chk("bad_c", operand_c, 40'h4444433333);
    chk("bad_err_pulses", err_cnt, 1);
    step();

    // ---- backpressure, next frame already waiting in the FIFO ----
    op_ready = 1'b0;
    push5(20'hA0006, 20'h00001, 20'h00002, 20'h00003, 20'h00004);
    push5(20'hA0009, 20'h0AAAA, 20'h0BBBB, 20'h0CCCC, 20'h0DDDD);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", op_valid, 1);
      chk("bp_rd", rd_en, 0);
      chk("bp_code", op_code, 4'h6);
      chk("bp_a", operand_a, 20'h00001);
      chk("bp_b", operand_b, 20'h00002);
      chk("bp_c", operand_c, 40'h0000400003);
      step();
    end
    op_ready = 1'b1;
    #1 chk("bp_c6_valid", op_valid, 1);
    step(); chk("bp_after_valid", op_valid, 0); chk("bp_after_rd", rd_en, 1);

    // ---- FIFO starvation after the B pop ----
    step(); step();
    step(); chk("st_b_pop", rd_en, 1);
    starve = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_hold_rd", rd_en, 0);
      chk("st_hold_busy", busy, 1);
      chk("st_hold_valid", op_valid, 0);
    end
    starve = 1'b0;
    step(); chk("st_clo_pop", rd_en, 1);
    step(); chk("st_chi_pop", rd_en, 1);
    step(); chk("st_s9_rd", rd_en, 0); chk("st_s9_valid", op_valid, 0);
    step(); chk("st_valid", op_valid, 1);
    chk("st_code", op_code, 4'h9);
    chk("st_a", operand_a, 20'h0AAAA);
    chk("st_b", operand_b, 20'h0BBBB);
    chk("st_c", operand_c, 40'h0DDDD0CCCC);
    step(); chk("st_after_valid", op_valid, 0);

    // ---- flush in the cycle after the C_lo pop ----
    q.push_back(20'hA000C); q.push_back(20'h11111);
    q.push_back(20'h22222); q.push_back(20'h33333);
    step(); chk("fl_hdr_pop", rd_en, 1);
    step(); step(); step();
    step(); chk("fl_clo_pop", rd_en, 1);
    step(); chk("fl_cyc_rd", rd_en, 0);
    flush = 1'b1;
    step(); flush = 1'b0;
    chk("fl_valid", op_valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_rd", rd_en, 0);
    push5(20'hA0007, 20'h55555, 20'h66666, 20'h77777, 20'h88888);
    wait_valid(n);
    chk("fl_code", op_code, 4'h7);
    chk("fl_a", operand_a, 20'h55555);
    chk("fl_b", operand_b, 20'h66666);
    chk("fl_c", operand_c, 40'h8888877777);
    chk("fl_err_pulses", err_cnt, 1);
    step();

    // ---- asynchronous reset while holding an operation ----
    op_ready = 1'b0;
    push5(20'hA000E, 20'h12345, 20'h6789A, 20'hBCDEF, 20'h01234);
    push5(20'hA0002, 20'h00010, 20'h00020, 20'h00030, 20'h00040);
    wait_valid(n);
    chk("rm_code_pre", op_code, 4'hE);
    arst_ni = 1'b0;
    #1;
    chk("rm_valid", op_valid, 0);
    chk("rm_rd", rd_en, 0);
    chk("rm_busy", busy, 0);
    chk("rm_code", op_code, 0);
    chk("rm_a", operand_a, 0);
    chk("rm_c", operand_c, 0);
    step(); step();
    arst_ni = 1'b1;
    op_ready = 1'b1;
    wait_valid(n);
    chk("rm2_code", op_code, 4'h2);
    chk("rm2_a", operand_a, 20'h00010);
    chk("rm2_b", operand_b, 20'h00020);
    chk("rm2_c", operand_c, 40'h0004000030);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
